start_trigger: RTL

START_TRIGGER -- requirements
Module: start_trigger

---
 rtl/start_trigger_pkg.sv | 29 ++
 rtl/start_trigger_ce_prescaler.sv | 46 ++++
 rtl/start_trigger.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/start_trigger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : start_trigger_pkg
//  Description : Shared types and constants for the start_trigger block.
//                Holds the debounce FSM state encoding and a decode helper
//                for the debounced level.
//  Revision    : 1.0 - initial release
// ============================================================================
package start_trigger_pkg;

    // Width of the debounce FSM state register
    localparam int c_state_w = 2;

    // Debounce FSM states, explicitly encoded
    typedef enum logic [c_state_w-1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } db_state_t;

    // The debounced level is high once a press has been accepted and stays
    // high while a release is still being qualified.
    function automatic logic level_of(input db_state_t s);
        return (s == ST_PRESSED) || (s == ST_RELEASE_CHK);
    endfunction

endpackage : start_trigger_pkg
`default_nettype wire

// File: rtl/start_trigger_ce_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : ce_prescaler
//  Description : Free-running modulo-PRESCALE counter producing a registered
//                one-cycle clock-enable tick once per PRESCALE clock cycles.
//                The tick is high for the cycle following each wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ce_prescaler #(
    parameter int PRESCALE      = 100,
    parameter int PRESCALE_SIZE = 7
) (
    input  logic i_clk,
    input  logic i_nrst,
    output logic o_ce
);

    // Terminal count of the prescaler, sized to the counter
    localparam logic [PRESCALE_SIZE-1:0] c_last = PRESCALE_SIZE'(PRESCALE - 1);
    localparam logic [PRESCALE_SIZE-1:0] c_one  = PRESCALE_SIZE'(1);

    logic [PRESCALE_SIZE-1:0] r_cnt;
    logic                     r_ce;
    logic                     w_wrap;

    assign w_wrap = (r_cnt == c_last);

    // Count 0..PRESCALE-1 and register the wrap as the enable tick
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
            r_ce <= w_wrap;
        end
    end

    assign o_ce = r_ce;

endmodule : ce_prescaler
`default_nettype wire

// File: rtl/start_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : start_trigger
//  Description : Turns a raw asynchronous trigger line into a clean one-cycle
//                start pulse for a downstream counter. The input is
//                synchronised, debounced on the prescaled tick, and a
//                qualified press issues o_start when the downstream block is
//                idle.
//                Build option START_TRIGGER_QUEUE_EN: when defined, a press
//                arriving while i_busy is high is held (depth one) and
//                released as soon as i_busy drops. When undefined, such a
//                press is dropped and o_pending is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module start_trigger
    import start_trigger_pkg::*;
#(
    parameter int PRESCALE       = 100,
    parameter int PRESCALE_SIZE  = 7,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int DEBOUNCE_SIZE  = 5
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_btn,
    input  logic i_busy,
    output logic o_ce,
    output logic o_start,
    output logic o_pending,
    output logic o_btn_level
);

    // Counter value at which the final qualifying tick is seen
    localparam logic [DEBOUNCE_SIZE-1:0] c_db_last = DEBOUNCE_SIZE'(DEBOUNCE_TICKS - 1);
    localparam logic [DEBOUNCE_SIZE-1:0] c_db_one  = DEBOUNCE_SIZE'(1);

    logic                     w_ce;
    logic                     r_sync1;
    logic                     r_sync2;
    db_state_t                r_state;
    db_state_t                w_state_next;
    logic [DEBOUNCE_SIZE-1:0] r_db_cnt;
    logic [DEBOUNCE_SIZE-1:0] w_db_cnt_next;
    logic                     w_press;
    logic                     w_level_next;
    logic                     r_level;
    logic                     w_blocked;
    logic                     w_start_next;
    logic                     r_start;

    // ------------------------------------------------------------------
    // Clock-enable generation
    // ------------------------------------------------------------------
    ce_prescaler #(
        .PRESCALE      (PRESCALE),
        .PRESCALE_SIZE (PRESCALE_SIZE)
    ) u_ce_prescaler (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .o_ce   (w_ce)
    );

    // Two-flop synchroniser for the raw trigger line
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------

    // State and debounce-counter register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= ST_RELEASED;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_db_cnt <= w_db_cnt_next;
        end
    end

    // Next state: a level change must be held for DEBOUNCE_TICKS ticks
    always_comb begin
        w_state_next  = r_state;
        w_db_cnt_next = r_db_cnt;
        unique case (r_state)
            ST_RELEASED: begin
                if (r_sync2) begin
                    w_state_next  = ST_PRESS_CHK;
                    w_db_cnt_next = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!r_sync2) begin
                    w_state_next  = ST_RELEASED;
                    w_db_cnt_next = '0;
                end else if (w_ce) begin
                    if (r_db_cnt == c_db_last) begin
                        w_state_next  = ST_PRESSED;
                        w_db_cnt_next = '0;
                    end else begin
                        w_db_cnt_next = r_db_cnt + c_db_one;
                    end
                end
            end
            ST_PRESSED: begin
                if (!r_sync2) begin
                    w_state_next  = ST_RELEASE_CHK;
                    w_db_cnt_next = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (r_sync2) begin
                    w_state_next  = ST_PRESSED;
                    w_db_cnt_next = '0;
                end else if (w_ce) begin
                    if (r_db_cnt == c_db_last) begin
                        w_state_next  = ST_RELEASED;
                        w_db_cnt_next = '0;
                    end else begin
                        w_db_cnt_next = r_db_cnt + c_db_one;
                    end
                end
            end
            default: begin
                w_state_next  = ST_RELEASED;
                w_db_cnt_next = '0;
            end
        endcase
    end

    // FSM outputs: press event and the next debounced level
    always_comb begin
        w_press      = (r_state == ST_PRESS_CHK) && (w_state_next == ST_PRESSED);
        w_level_next = level_of(w_state_next);
    end

    // ------------------------------------------------------------------
    // Start issue / queueing
    // ------------------------------------------------------------------

    // A start cannot go out while downstream is busy, nor on the cycle
    // straight after another start.
    assign w_blocked = i_busy || r_start;

`ifdef START_TRIGGER_QUEUE_EN
    logic r_pending;
    logic w_pending_next;

    // Issue on an unblocked press or pending request; hold one blocked press
    always_comb begin
        w_start_next = !w_blocked && (w_press || r_pending);
        if (r_pending) begin
            w_pending_next = w_blocked;
        end else begin
            w_pending_next = w_press && w_blocked;
        end
    end

    // Pending-request flag
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign o_pending = r_pending;
`else
    // A blocked press is simply discarded
    always_comb begin
        w_start_next = w_press && !w_blocked;
    end

    assign o_pending = 1'b0;
`endif

    // Registered outputs, aligned with the FSM state update
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_start <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_start <= w_start_next;
            r_level <= w_level_next;
        end
    end

    assign o_ce        = w_ce;
    assign o_start     = r_start;
    assign o_btn_level = r_level;

endmodule : start_trigger
`default_nettype wire
